iter_div_unit: RTL and testbench
================================

# iter_div_unit

Iterative radix-2 divider serving the execute stage's ALU for `div.w`/`div.wu`/`mod.w`/`mod.wu`. It accepts the enable, signedness and operands the execute stage drives, computes quotient and remainder over 32 iteration cycles, and holds `div_complete_o` with stable results until the execute stage acknowledges the instruction has left. An exception flush from writeback aborts any division in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the counter width is derived as clog2(WIDTH)+1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_en_i`  in  1  a division is requested; held high by execute while the divide instruction occupies it.
- `div_sign_i`  in  1  1 = signed, 0 = unsigned; sampled only at start.
- `dividend_i`  in  WIDTH  dividend; sampled only at start.
- `divisor_i`  in  WIDTH  divisor; sampled only at start.
- `div_ack_i`  in  1  execute hands the divide instruction to memory this cycle (ex_to_mem_valid & mem_allowin).
- `flush_i`  in  1  exception flush; aborts the current operation.
- `quotient_o`  out  WIDTH  registered quotient.
- `remainder_o`  out  WIDTH  registered remainder.
- `div_complete_o`  out  1  results valid; high only in state DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `div_en_i`=1, `flush_i`=0, divisor ≠ 0:
  - capture |dividend| and |divisor| (absolute values only when signed);
  - record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend), both only when signed;
  - clear the partial remainder and the counter; go to CALC.
- IDLE, `div_en_i`=1, `flush_i`=0, divisor = 0: go straight to DONE with quotient 32'hFFFF_FFFF and remainder = `dividend_i` unmodified, for either signedness.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - The counter increments every step. After step WIDTH, go to DONE.
  - On that DONE transition, register the outputs with sign fix-up: quotient negated if q_neg, remainder negated if r_neg (two's complement, modulo 2^WIDTH).
- DONE: `div_complete_o`=1 and the outputs are held stable.
  - `div_ack_i`=1: go to IDLE.
  - Otherwise stay, even if the input operands change.
- Overflow case: 0x8000_0000 / -1, signed, yields quotient 0x8000_0000 and remainder 0 through the normal datapath. No special case.
- `flush_i`=1 in any state: IDLE next cycle, `div_complete_o`=0. Flush overrides start and ack in the same cycle; no start occurs in a flush cycle.
- Changes to `div_en_i` or the operands during CALC are ignored. Deasserting `div_en_i` without a flush does not abort the operation.
- Reset: state IDLE, `quotient_o`=0, `remainder_o`=0, `div_complete_o`=0, counter 0, all internal registers 0.

## Timing
- Cycle 0: `div_en_i` sampled high in IDLE.
- Cycles 1..32: CALC.
- Cycle 33: DONE, `div_complete_o`=1. Normal latency is 33 cycles from start to complete.
- Divide by zero: DONE in cycle 1, a latency of 1.
- Ack in DONE at cycle k: IDLE at k+1. A new `div_en_i` seen at k+1 starts the next division, so the minimum back-to-back issue interval is 34 cycles.
- `div_complete_o` never asserts in IDLE or CALC, and never in the cycle after a flush.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared header `DefineDiv.h` holds:
  - state encodings `DivIdle`/`DivCalc`/`DivDone` and `DivStateWidth`;
  - `DivIterNum` (32).
- Keep the module flat. The restoring step, abs and negate logic are a few lines each and do not justify a sub-module.
- Top level: execute's ALU drives `div_en_i`, `div_sign_i`, `dividend_i` and `divisor_i`. `quotient_o`, `remainder_o` and `div_complete_o` return to the ALU's div_complete/quotient/remainder inputs. `flush_i` is the same excep_flush execute receives.

## Test plan
- Unsigned 100 / 7, held en, no ack → complete in cycle 33, q=14, r=2; held unchanged for 5 cycles; ack → IDLE next cycle.
- Signed -7 / 2 → q=0xFFFF_FFFD, r=0xFFFF_FFFF; signed 7 / -2 → q=0xFFFF_FFFD, r=1; unsigned 0xFFFF_FFFF / 2 → q=0x7FFF_FFFF, r=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → q=0x8000_0000, r=0, complete in cycle 33.
- Divide by zero, 5 / 0, signed and unsigned → complete in cycle 1, q=0xFFFF_FFFF, r=5.
- Flush in cycle 10 of CALC → complete stays 0, IDLE in cycle 11. Re-issue 100/7 → complete exactly 33 cycles after the new start. Flush and ack together in DONE → IDLE, no restart in that cycle.
- Back-to-back: ack in the DONE cycle, new operands 50/5 with en high the next cycle → q=10, r=0, complete 33 cycles after the second start. Operand changes during CALC do not alter the results.

Source files
------------

// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative radix-2 divider: state encoding and iteration count.
package iter_div_unit_pkg;

    localparam int unsigned DIV_ITER_NUM    = 32;
    localparam int unsigned DIV_STATE_WIDTH = 2;

    typedef enum logic [DIV_STATE_WIDTH-1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : iter_div_unit_pkg

// File: rtl/iter_div_unit.sv
// Iterative restoring divider for div.w/div.wu/mod.w/mod.wu: one quotient bit per cycle,
// results held in DONE until execute acknowledges, aborted by an exception flush.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER_NUM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en_i,
    input  logic             div_sign_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             div_ack_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_complete_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             complete_d;

    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic             dvd_neg, dvs_neg;

    // Operand magnitudes; negation only applies to signed operations.
    always_comb begin
        dvd_neg = div_sign_i & dividend_i[WIDTH-1];
        dvs_neg = div_sign_i & divisor_i[WIDTH-1];
        dvd_abs = dvd_neg ? -dividend_i : dividend_i;
        dvs_abs = dvs_neg ? -divisor_i  : divisor_i;
    end

    // One restoring step; the shifted remainder keeps an extra bit so large divisors cannot overflow.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_sh[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath/output next values; flush overrides everything else.
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_o;
        remainder_d = remainder_o;
        complete_d  = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (div_en_i && !flush_i) begin
                    if (divisor_i == '0) begin
                        state_d     = DIV_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        complete_d  = 1'b1;
                    end else begin
                        state_d = DIV_CALC;
                        quo_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DIV_DONE;
                    complete_d  = 1'b1;
                    quotient_d  = q_neg_q ? -step_quo : step_quo;
                    remainder_d = r_neg_q ? -step_rem : step_rem;
                end
            end
            DIV_DONE: begin
                complete_d = 1'b1;
                if (div_ack_i) begin
                    state_d    = DIV_IDLE;
                    complete_d = 1'b0;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d    = DIV_IDLE;
            complete_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q          <= '0;
            dvs_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            quotient_o     <= '0;
            remainder_o    <= '0;
            div_complete_o <= 1'b0;
        end else begin
            quo_q          <= quo_d;
            dvs_q          <= dvs_d;
            rem_q          <= rem_d;
            cnt_q          <= cnt_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            quotient_o     <= quotient_d;
            remainder_o    <= remainder_d;
            div_complete_o <= complete_d;
        end
    end

endmodule : iter_div_unit

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: driver pushes expected results, monitor checks completions.
module tb_iter_div_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_en;
    logic        div_sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_ack;
    logic        flush;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_complete;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_complete = 1'b0;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .div_en_i       (div_en),
        .div_sign_i     (div_sign),
        .dividend_i     (dividend),
        .divisor_i      (divisor),
        .div_ack_i      (div_ack),
        .flush_i        (flush),
        .quotient_o     (quotient),
        .remainder_o    (remainder),
        .div_complete_o (div_complete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; divide by zero gives all ones and the raw dividend.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint la, lb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q  = 32'(la / lb);
            r  = 32'(la % lb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present a start request at the current negedge and push the given expectation.
    task automatic start_exp(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        div_en   = 1'b1;
        div_sign = s;
        dividend = a;
        divisor  = b;
        e.q      = q;
        e.r      = r;
        e.lat    = (b == 32'd0) ? 1 : 33;
        e.start  = cyc;
        sb.push_back(e);
    endtask

    task automatic start_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        ref_div(s, a, b, q, r);
        start_exp(s, a, b, q, r);
    endtask

    // Wait (bounded) for completion, hold some cycles, then acknowledge; optionally scramble inputs.
    task automatic finish_op(input int hold, input bit scramble);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (scramble) begin
                div_sign = 1'($urandom);
                dividend = $urandom;
                divisor  = $urandom;
            end
            n++;
        end while (!div_complete && n < 60);
        if (!div_complete) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: got no complete after %0d cycles expected complete", n);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                if (scramble) begin
                    dividend = $urandom;
                    divisor  = $urandom;
                end
            end
            div_ack = 1'b1;
            @(negedge clk);
            div_ack = 1'b0;
            div_en  = 1'b0;
            chk("complete_low_after_ack", 32'(div_complete), 32'd0);
        end
    endtask

    // Monitor: pop on each rising complete, then require stable results while it stays high.
    always @(negedge clk) begin
        if (rst) begin
            prev_complete = 1'b0;
        end else begin
            if (div_complete && !prev_complete) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_complete: got complete=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    cur = sb.pop_front();
                    chk("quotient", quotient, cur.q);
                    chk("remainder", remainder, cur.r);
                    chk("latency", 32'(cyc - cur.start), 32'(cur.lat));
                end
            end else if (div_complete && prev_complete) begin
                chk("quotient_hold", quotient, cur.q);
                chk("remainder_hold", remainder, cur.r);
            end
            prev_complete = div_complete;
        end
    end

    initial begin
        int mode;
        logic [31:0] a, b;
        rst      = 1'b1;
        div_en   = 1'b0;
        div_sign = 1'b0;
        dividend = '0;
        divisor  = '0;
        div_ack  = 1'b0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_complete", 32'(div_complete), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from hand-derived results.
        start_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        finish_op(5, 1'b0);
        @(negedge clk);
        start_exp(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        finish_op(0, 1'b1);
        start_exp(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        finish_op(1, 1'b0);
        start_exp(1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
        finish_op(0, 1'b0);
        start_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        finish_op(2, 1'b1);
        start_exp(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        finish_op(0, 1'b0);
        start_exp(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        finish_op(3, 1'b0);

        // Flush in the middle of CALC: nothing may complete.
        @(negedge clk);
        div_en = 1'b1; div_sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
        repeat (10) @(negedge clk);
        flush  = 1'b1;
        div_en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("complete_low_after_flush", 32'(div_complete), 32'd0);
        repeat (40) @(negedge clk);
        chk("no_complete_after_calc_flush", 32'(div_complete), 32'd0);

        // Re-issue, then back-to-back with operands scrambled during CALC.
        start_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        finish_op(0, 1'b1);
        start_exp(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
        finish_op(0, 1'b1);

        // Flush together with ack and a new request in DONE: no restart.
        start_exp(1'b0, 32'd20, 32'd3, 32'd6, 32'd2);
        finish_op(1, 1'b0);
        start_exp(1'b0, 32'd21, 32'd4, 32'd5, 32'd1);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!div_complete && n < 60);
        end
        chk("complete_before_flush_ack", 32'(div_complete), 32'd1);
        flush = 1'b1; div_ack = 1'b1; div_en = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        flush = 1'b0; div_ack = 1'b0; div_en = 1'b0;
        chk("complete_low_after_flush_ack", 32'(div_complete), 32'd0);
        repeat (40) @(negedge clk);
        chk("no_restart_after_flush_ack", 32'(div_complete), 32'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            start_model(1'($urandom), a, b);
            finish_op(int'($urandom_range(0, 3)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iter_div_unit
